mfi_reg_track_check: RTL and testbench
======================================

Name: mfi_reg_track_check

Overview:
- Sequential, multi-retire register-consistency checker on the MFI retirement interface.
- Keeps a shadow register file from retired destination writes. Each later source read must return the last value retired to that register.
- Also checks that retirement order is gap-free and monotonic across NRET channels per cycle.
- Sits beside the per-instruction spec checks in the formal and simulation harness. It adds the cross-instruction behaviour that a single-instruction check cannot see.

Parameters:
- NRET, 2, retirement channels per cycle; channel 0 is oldest.
- XLEN, 32, register data width.
- NREGS, 16, architectural registers; address width is $clog2(NREGS).
- PC_REG, 15, register index aliased to PC; never tracked or checked.
- ORDER_W, 64, width of the retirement order tag.
- DEPTH, 32, retirements to track before declaring done.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- check_en  in  1  start tracking (level; sampled only in IDLE)
- mfi_valid  in  NRET  per-channel retire valid
- mfi_order  in  NRET*ORDER_W  per-channel order tag
- mfi_trap  in  NRET  instruction trapped; no dest write
- mfi_src1_addr/src2_addr/src3_addr  in  NRET*$clog2(NREGS) each  source addresses
- mfi_src1_rdata/src2_rdata/src3_rdata  in  NRET*XLEN each  source read data
- mfi_dest_addr  in  NRET*$clog2(NREGS)  destination address
- mfi_dest_wdata  in  NRET*XLEN  destination write data
- busy  out  1  state is TRACK
- done  out  1  DEPTH retirements checked without failure
- fail  out  1  sticky failure flag
- fail_cause  out  2  0 NONE, 1 GAP, 2 ORDER, 3 RDATA
- fail_chan  out  $clog2(NRET) (min 1)  channel of the first failure
- retired_cnt  out  $clog2(DEPTH+1)  retirements checked so far

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; all outputs 0; shadow valid bits cleared; expected-order register cleared; first_seen=0.
  - Reset mid-TRACK aborts tracking with no residual state.
- States: IDLE, TRACK, DONE, FAIL. Outputs are registered and reflect the retirement one cycle later.
- IDLE:
  - Shadow valid bits are held clear.
  - check_en==1 moves to TRACK next cycle. Retirements in the same cycle as the IDLE-to-TRACK decision are ignored.
- TRACK: each cycle, process channels 0..NRET-1 in ascending order.
  - GAP: mfi_valid[k] && !mfi_valid[k-1] for any k>0.
  - ORDER:
    - First valid retirement after entering TRACK latches expected = mfi_order[0]; no order failure is possible on that cycle.
    - Afterwards, valid channel k needs mfi_order[k] == expected + k (mod 2^ORDER_W).
    - expected advances by the number of valid channels in the cycle.
  - RDATA:
    - For each valid channel and each of src1..3: if addr != PC_REG and shadow_valid[addr], then rdata must equal shadow[addr].
    - Sources of channel k see writes from channels <k in the same cycle (in-order bypass).
    - Unwritten registers are not checked.
  - Update: a valid channel with !mfi_trap and dest_addr != PC_REG writes shadow[dest] and sets shadow_valid[dest].
    - Two channels writing the same register in one cycle: the higher channel wins.
    - A trapped instruction's reads are still checked; it makes no write.
  - Any failure: state goes to FAIL and fail=1. fail_cause/fail_chan record the lowest failing channel. Within that channel the priority is GAP > ORDER > RDATA.
  - Otherwise retired_cnt += popcount(valid). Once it reaches or exceeds DEPTH, go to DONE. retired_cnt saturates at DEPTH.
  - A failure and reaching DEPTH in the same cycle goes to FAIL.
- DONE and FAIL: terminal until reset; inputs ignored; outputs held.
- Formal build: assert(!fail) each cycle; cover(done); cover(state==TRACK with NRET channels all valid).

Decomposition:
- Package mfi_check_pkg holds the state enum, the fail_cause enum, and localparam address-width helpers.
- Sub-module mfi_shadow_rf:
  - NREGS x XLEN storage plus valid bits.
  - NRET ordered write ports and 3*NRET read ports.
  - Read port k returns the bypassed value from lower channels.
  - Exposes hit/valid per read port.
- The top block holds the FSM, order counter and failure priority logic.

Test Plan:
- Reset held low 3 cycles with check_en=1 -> all outputs 0, state IDLE; first edge with reset=1 moves to TRACK one cycle later.
- ch0 writes r3=0xDEADBEEF (order 10), next cycle ch0 reads r3=0xDEADBEEF (order 11) -> no fail, retired_cnt=2.
- Same cycle: ch0 writes r5=0x11, ch1 reads r5=0x22 -> fail=1, fail_cause=3, fail_chan=1 next cycle; ch1 reading 0x11 instead -> pass.
- mfi_valid=2'b10 -> fail_cause=1, fail_chan=1; order tags 20 then 22 on successive single retirements -> fail_cause=2, fail_chan=0.
- Trapped ch0 with dest r2=0x5, then read r2=0x7 with r2 previously unwritten -> no fail; dest r15 writes are never checked.
- DEPTH=32, NRET=2, 16 clean double retirements -> done=1, retired_cnt=32, busy=0; reset mid-run at count 9 -> all outputs clear.

Source files
------------

// File: rtl/mfi_check_pkg.sv
// Shared types and width helpers for the MFI register-tracking checker.
package mfi_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_GAP   = 2'd1,
        CAUSE_ORDER = 2'd2,
        CAUSE_RDATA = 2'd3
    } fail_cause_t;

    // Source operands per retired instruction.
    localparam int NSRC = 3;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mfi_shadow_rf.sv
// Shadow register file: NRET ordered write ports, NSRC*NRET bypassed read ports.
// Latency: reads combinational (incl. same-cycle bypass from lower channels), writes visible next cycle.
// Backpressure: none; every write/read is accepted every cycle.
module mfi_shadow_rf
    import mfi_check_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int NREGS = 16,
    localparam int AW   = idx_w(NREGS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [NRET-1:0]               wr_en,
    input  logic [NRET*AW-1:0]            wr_addr,
    input  logic [NRET*XLEN-1:0]          wr_data,
    input  logic [NSRC*NRET*AW-1:0]       rd_addr,
    output logic [NSRC*NRET*XLEN-1:0]     rd_data,
    output logic [NSRC*NRET-1:0]          rd_hit
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] vld;

    // Ascending loop order makes the highest channel win on a same-register collision.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            vld <= '0;
        end else begin
            for (int j = 0; j < NRET; j++) begin
                if (wr_en[j]) begin
                    vld[wr_addr[j*AW +: AW]] <= 1'b1;
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Port p belongs to channel p/NSRC and sees writes from all lower channels.
    always_comb begin
        rd_data = '0;
        rd_hit  = '0;
        for (int p = 0; p < NSRC*NRET; p++) begin
            rd_hit[p]               = vld[rd_addr[p*AW +: AW]];
            rd_data[p*XLEN +: XLEN] = mem[rd_addr[p*AW +: AW]];
            for (int j = 0; j < NRET; j++) begin
                if (j < p/NSRC && wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[p*AW +: AW]) begin
                    rd_hit[p]               = 1'b1;
                    rd_data[p*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/mfi_reg_track_check.sv
// Cross-instruction register/order consistency checker on the MFI retirement interface.
// Latency: verdict and counters registered, one cycle after the retirement.
// Backpressure: none; observes every retirement, terminal in DONE/FAIL until reset.
module mfi_reg_track_check
    import mfi_check_pkg::*;
#(
    parameter int NRET    = 2,
    parameter int XLEN    = 32,
    parameter int NREGS   = 16,
    parameter int PC_REG  = 15,
    parameter int ORDER_W = 64,
    parameter int DEPTH   = 32,
    localparam int AW     = idx_w(NREGS),
    localparam int CW     = idx_w(NRET),
    localparam int CNT_W  = $clog2(DEPTH+1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    check_en,
    input  logic [NRET-1:0]         mfi_valid,
    input  logic [NRET*ORDER_W-1:0] mfi_order,
    input  logic [NRET-1:0]         mfi_trap,
    input  logic [NRET*AW-1:0]      mfi_src1_addr,
    input  logic [NRET*AW-1:0]      mfi_src2_addr,
    input  logic [NRET*AW-1:0]      mfi_src3_addr,
    input  logic [NRET*XLEN-1:0]    mfi_src1_rdata,
    input  logic [NRET*XLEN-1:0]    mfi_src2_rdata,
    input  logic [NRET*XLEN-1:0]    mfi_src3_rdata,
    input  logic [NRET*AW-1:0]      mfi_dest_addr,
    input  logic [NRET*XLEN-1:0]    mfi_dest_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [1:0]              fail_cause,
    output logic [CW-1:0]           fail_chan,
    output logic [CNT_W-1:0]        retired_cnt
);

    state_t               state_q, state_d;
    logic                 first_q, first_d;
    logic [ORDER_W-1:0]   exp_q, exp_d, exp_base;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d, fail_q, fail_d;
    fail_cause_t          cause_q, cause_d, chk_cause, ch_cause;
    logic [CW-1:0]        chan_q, chan_d, chk_chan;
    logic                 chk_fail, prev_vld;
    logic [CNT_W:0]       nvalid, cnt_sum;

    logic [NRET-1:0]             wr_en;
    logic [NSRC*NRET*AW-1:0]     rd_addr;
    logic [NSRC*NRET*XLEN-1:0]   rd_data, src_rdata;
    logic [NSRC*NRET-1:0]        rd_hit;

    always_comb begin
        rd_addr   = '0;
        src_rdata = '0;
        wr_en     = '0;
        for (int k = 0; k < NRET; k++) begin
            rd_addr[(k*NSRC+0)*AW +: AW]     = mfi_src1_addr[k*AW +: AW];
            rd_addr[(k*NSRC+1)*AW +: AW]     = mfi_src2_addr[k*AW +: AW];
            rd_addr[(k*NSRC+2)*AW +: AW]     = mfi_src3_addr[k*AW +: AW];
            src_rdata[(k*NSRC+0)*XLEN +: XLEN] = mfi_src1_rdata[k*XLEN +: XLEN];
            src_rdata[(k*NSRC+1)*XLEN +: XLEN] = mfi_src2_rdata[k*XLEN +: XLEN];
            src_rdata[(k*NSRC+2)*XLEN +: XLEN] = mfi_src3_rdata[k*XLEN +: XLEN];
            wr_en[k] = (state_q == ST_TRACK) && mfi_valid[k] && !mfi_trap[k] &&
                       (mfi_dest_addr[k*AW +: AW] != AW'(PC_REG));
        end
    end

    mfi_shadow_rf #(.NRET(NRET), .XLEN(XLEN), .NREGS(NREGS)) u_shadow (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q == ST_IDLE),
        .wr_en   (wr_en),
        .wr_addr (mfi_dest_addr),
        .wr_data (mfi_dest_wdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_hit  (rd_hit)
    );

    // Per-channel verdict; the lowest failing channel is the one reported.
    always_comb begin
        chk_fail  = 1'b0;
        chk_cause = CAUSE_NONE;
        chk_chan  = '0;
        prev_vld  = 1'b1;
        exp_base  = first_q ? exp_q : mfi_order[ORDER_W-1:0];
        for (int k = 0; k < NRET; k++) begin
            ch_cause = CAUSE_NONE;
            if (mfi_valid[k]) begin
                if (!prev_vld) begin
                    ch_cause = CAUSE_GAP;
                end else if (first_q && mfi_order[k*ORDER_W +: ORDER_W] != exp_base + ORDER_W'(k)) begin
                    ch_cause = CAUSE_ORDER;
                end else begin
                    for (int s = 0; s < NSRC; s++) begin
                        if (rd_hit[k*NSRC+s] && rd_addr[(k*NSRC+s)*AW +: AW] != AW'(PC_REG) &&
                            rd_data[(k*NSRC+s)*XLEN +: XLEN] != src_rdata[(k*NSRC+s)*XLEN +: XLEN])
                            ch_cause = CAUSE_RDATA;
                    end
                end
            end
            if (ch_cause != CAUSE_NONE && !chk_fail) begin
                chk_fail  = 1'b1;
                chk_cause = ch_cause;
                chk_chan  = CW'(k);
            end
            prev_vld = mfi_valid[k];
        end
    end

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        fail_d  = fail_q;
        cause_d = cause_q;
        chan_d  = chan_q;
        nvalid  = (CNT_W+1)'($countones(mfi_valid));
        cnt_sum = {1'b0, cnt_q} + nvalid;
        case (state_q)
            ST_IDLE: begin
                first_d = 1'b0;
                exp_d   = '0;
                if (check_en) state_d = ST_TRACK;
            end
            ST_TRACK: begin
                if (chk_fail) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                    cause_d = chk_cause;
                    chan_d  = chk_chan;
                end else begin
                    if (nvalid != '0) begin
                        first_d = 1'b1;
                        exp_d   = exp_base + ORDER_W'(nvalid);
                    end
                    if (cnt_sum >= (CNT_W+1)'(DEPTH)) begin
                        cnt_d   = CNT_W'(DEPTH);
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_sum[CNT_W-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
            exp_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            cause_q <= cause_d;
            chan_q  <= chan_d;
        end
    end

    assign busy        = (state_q == ST_TRACK);
    assign done        = done_q;
    assign fail        = fail_q;
    assign fail_cause  = cause_q;
    assign fail_chan   = chan_q;
    assign retired_cnt = cnt_q;

`ifdef FORMAL
    always @(posedge clock) begin
        if (reset) begin
            assert (!fail_q);
            cover (done_q);
            cover (state_q == ST_TRACK && &mfi_valid);
        end
    end
`endif

endmodule

// File: tb/tb_mfi_reg_track_check.sv
// Randomized + directed bench for mfi_reg_track_check against a sequential per-instruction model.
module tb_mfi_reg_track_check;

    logic         clock = 1'b0;
    logic         reset, check_en;
    logic [1:0]   mfi_valid, mfi_trap;
    logic [127:0] mfi_order;
    logic [7:0]   mfi_src1_addr, mfi_src2_addr, mfi_src3_addr, mfi_dest_addr;
    logic [63:0]  mfi_src1_rdata, mfi_src2_rdata, mfi_src3_rdata, mfi_dest_wdata;
    logic         busy, done, fail;
    logic [1:0]   fail_cause;
    logic [0:0]   fail_chan;
    logic [5:0]   retired_cnt;

    always #5 clock = ~clock;

    // Stimulus, one entry per channel.
    logic        v[2], trap[2];
    logic [63:0] ord[2];
    logic [3:0]  sa[2][3], da[2];
    logic [31:0] sd[2][3], dd[2];

    always_comb begin
        mfi_valid = '0; mfi_trap = '0; mfi_order = '0;
        mfi_src1_addr = '0; mfi_src2_addr = '0; mfi_src3_addr = '0; mfi_dest_addr = '0;
        mfi_src1_rdata = '0; mfi_src2_rdata = '0; mfi_src3_rdata = '0; mfi_dest_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            mfi_valid[k] = v[k];
            mfi_trap[k]  = trap[k];
            mfi_order[k*64 +: 64]      = ord[k];
            mfi_src1_addr[k*4 +: 4]    = sa[k][0];
            mfi_src2_addr[k*4 +: 4]    = sa[k][1];
            mfi_src3_addr[k*4 +: 4]    = sa[k][2];
            mfi_src1_rdata[k*32 +: 32] = sd[k][0];
            mfi_src2_rdata[k*32 +: 32] = sd[k][1];
            mfi_src3_rdata[k*32 +: 32] = sd[k][2];
            mfi_dest_addr[k*4 +: 4]    = da[k];
            mfi_dest_wdata[k*32 +: 32] = dd[k];
        end
    end

    mfi_reg_track_check dut (
        .clock(clock), .reset(reset), .check_en(check_en),
        .mfi_valid(mfi_valid), .mfi_order(mfi_order), .mfi_trap(mfi_trap),
        .mfi_src1_addr(mfi_src1_addr), .mfi_src2_addr(mfi_src2_addr), .mfi_src3_addr(mfi_src3_addr),
        .mfi_src1_rdata(mfi_src1_rdata), .mfi_src2_rdata(mfi_src2_rdata), .mfi_src3_rdata(mfi_src3_rdata),
        .mfi_dest_addr(mfi_dest_addr), .mfi_dest_wdata(mfi_dest_wdata),
        .busy(busy), .done(done), .fail(fail), .fail_cause(fail_cause),
        .fail_chan(fail_chan), .retired_cnt(retired_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 tracking, 2 done, 3 failed.
    int          m_state, m_cause, m_chan, m_cnt;
    bit          m_first, m_fail, m_done;
    logic [63:0] m_exp;
    logic [31:0] m_shadow[16];
    bit          m_sv[16];

    task automatic model_step();
        logic [31:0] w[16];
        bit          wv[16];
        bit          failed, prev;
        int          cause, nv;
        if (!reset) begin
            m_state = 0; m_first = 0; m_exp = '0; m_cnt = 0;
            m_fail = 0; m_done = 0; m_cause = 0; m_chan = 0;
            for (int r = 0; r < 16; r++) m_sv[r] = 0;
            return;
        end
        if (m_state == 0) begin
            for (int r = 0; r < 16; r++) m_sv[r] = 0;
            if (check_en) m_state = 1;
        end else if (m_state == 1) begin
            w = m_shadow; wv = m_sv; failed = 0; prev = 1; nv = 0;
            // Retire instructions one at a time, oldest first.
            for (int k = 0; k < 2; k++) begin
                if (v[k]) begin
                    nv++;
                    cause = 0;
                    if (!prev) cause = 1;
                    else if (m_first && ord[k] != m_exp + 64'(k)) cause = 2;
                    else
                        for (int s = 0; s < 3; s++)
                            if (sa[k][s] != 4'd15 && wv[sa[k][s]] && sd[k][s] != w[sa[k][s]]) cause = 3;
                    if (cause != 0 && !failed) begin failed = 1; m_cause = cause; m_chan = k; end
                    if (!trap[k] && da[k] != 4'd15) begin w[da[k]] = dd[k]; wv[da[k]] = 1; end
                end
                prev = v[k];
            end
            if (failed) begin
                m_state = 3; m_fail = 1;
            end else begin
                m_shadow = w; m_sv = wv;
                if (nv > 0) begin
                    if (!m_first) begin m_exp = ord[0]; m_first = 1; end
                    m_exp = m_exp + 64'(nv);
                end
                m_cnt += nv;
                if (m_cnt >= 32) begin m_cnt = 32; m_done = 1; m_state = 2; end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic clr_stim();
        for (int k = 0; k < 2; k++) begin
            v[k] = 0; trap[k] = 0; ord[k] = '0; da[k] = 4'd15; dd[k] = $urandom;
            for (int s = 0; s < 3; s++) begin sa[k][s] = 4'd15; sd[k][s] = $urandom; end
        end
    endtask

    // Reset, then enter TRACK with junk retirements on the entry cycle.
    task automatic enter_track();
        reset = 0; check_en = 0; clr_stim();
        step();
        reset = 1; check_en = 1;
        v[0] = 1'($urandom_range(0, 1)); v[1] = 1'($urandom_range(0, 1));
        da[0] = 4'($urandom_range(0, 7)); ord[0] = {$urandom, $urandom};
        step();
        check_en = 0; clr_stim();
    endtask

    function automatic logic [3:0] pick_reg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 4'd15 : 4'(r);
    endfunction

    // pat: 0 random, 1 both channels, 2 channel 0 only. err: 1-in-err fault injection (0 = none).
    task automatic gen_cycle(input int pat, input int err);
        logic [63:0] base;
        logic [3:0]  a;
        int          r;
        clr_stim();
        r = $urandom_range(0, 9);
        if (pat == 1) begin v[0] = 1; v[1] = 1; end
        else if (pat == 2) v[0] = 1;
        else begin v[0] = (r >= 3); v[1] = (r >= 6); end
        if (err != 0 && $urandom_range(0, err-1) == 0) begin v[0] = 0; v[1] = 1; end
        base = m_first ? m_exp : {$urandom, $urandom};
        for (int k = 0; k < 2; k++) begin
            ord[k] = base + 64'(k);
            if (err != 0 && $urandom_range(0, err-1) == 0) ord[k] = ord[k] + 64'd1;
            trap[k] = ($urandom_range(0, 7) == 0);
            da[k] = pick_reg(); dd[k] = $urandom;
            for (int s = 0; s < 3; s++) begin
                a = pick_reg(); sa[k][s] = a;
                if (k == 1 && v[0] && !trap[0] && da[0] != 4'd15 && da[0] == a) sd[k][s] = dd[0];
                else if (m_sv[a]) sd[k][s] = m_shadow[a];
                else sd[k][s] = $urandom;
                if (err != 0 && $urandom_range(0, err-1) == 0) sd[k][s] ^= (32'h1 << $urandom_range(0, 31));
            end
        end
    endtask

    task automatic test_reset();
        reset = 0; check_en = 1; clr_stim();
        repeat (3) step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail: got %0b want 0", fail); end
        total++; if (fail_cause !== 2'd0) begin bad++; $display("FAIL reset_cause: got %0d want 0", fail_cause); end
        total++; if (fail_chan !== 1'b0) begin bad++; $display("FAIL reset_chan: got %0d want 0", fail_chan); end
        total++; if (retired_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", retired_cnt); end
        reset = 1;
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_to_track: busy got %0b want 1", busy); end
        check_en = 0;
    endtask

    task automatic test_bypass_next_cycle();
        enter_track();
        v[0] = 1; ord[0] = 64'd10; da[0] = 4'd3; dd[0] = 32'hDEADBEEF;
        step();
        clr_stim(); v[0] = 1; ord[0] = 64'd11; sa[0][0] = 4'd3; sd[0][0] = 32'hDEADBEEF;
        step();
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL r3_read_fail: got %0b want 0", fail); end
        total++; if (retired_cnt !== 6'd2) begin bad++; $display("FAIL r3_read_cnt: got %0d want 2", retired_cnt); end
    endtask

    task automatic test_same_cycle_bypass();
        enter_track();
        v[0] = 1; v[1] = 1; ord[0] = 64'd0; ord[1] = 64'd1;
        da[0] = 4'd5; dd[0] = 32'h11; sa[1][0] = 4'd5; sd[1][0] = 32'h22;
        step();
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL bypass_bad_fail: got %0b want 1", fail); end
        total++; if (fail_cause !== 2'd3) begin bad++; $display("FAIL bypass_bad_cause: got %0d want 3", fail_cause); end
        total++; if (fail_chan !== 1'b1) begin bad++; $display("FAIL bypass_bad_chan: got %0d want 1", fail_chan); end
        enter_track();
        v[0] = 1; v[1] = 1; ord[0] = 64'd0; ord[1] = 64'd1;
        da[0] = 4'd5; dd[0] = 32'h11; sa[1][0] = 4'd5; sd[1][0] = 32'h11;
        step();
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL bypass_ok_fail: got %0b want 0", fail); end
        total++; if (retired_cnt !== 6'd2) begin bad++; $display("FAIL bypass_ok_cnt: got %0d want 2", retired_cnt); end
    endtask

    task automatic test_gap_and_order();
        enter_track();
        v[1] = 1; ord[0] = 64'd4; ord[1] = 64'd5;
        step();
        total++; if (fail_cause !== 2'd1) begin bad++; $display("FAIL gap_cause: got %0d want 1", fail_cause); end
        total++; if (fail_chan !== 1'b1) begin bad++; $display("FAIL gap_chan: got %0d want 1", fail_chan); end
        enter_track();
        v[0] = 1; ord[0] = 64'd20;
        step();
        ord[0] = 64'd22;
        step();
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL order_fail: got %0b want 1", fail); end
        total++; if (fail_cause !== 2'd2) begin bad++; $display("FAIL order_cause: got %0d want 2", fail_cause); end
        total++; if (fail_chan !== 1'b0) begin bad++; $display("FAIL order_chan: got %0d want 0", fail_chan); end
        total++; if (retired_cnt !== 6'd1) begin bad++; $display("FAIL order_cnt: got %0d want 1", retired_cnt); end
        ord[0] = 64'd21; v[1] = 1; ord[1] = 64'd22;
        step();
        total++; if (fail !== 1'b1 || retired_cnt !== 6'd1 || busy !== 1'b0) begin
            bad++; $display("FAIL fail_hold: fail=%0b cnt=%0d busy=%0b want 1/1/0", fail, retired_cnt, busy);
        end
    endtask

    task automatic test_trap_and_pc();
        enter_track();
        v[0] = 1; trap[0] = 1; ord[0] = 64'd0; da[0] = 4'd2; dd[0] = 32'h5;
        step();
        clr_stim(); v[0] = 1; ord[0] = 64'd1; sa[0][0] = 4'd2; sd[0][0] = 32'h7;
        step();
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL trap_nowrite: fail got %0b want 0", fail); end
        clr_stim(); v[0] = 1; ord[0] = 64'd2; da[0] = 4'd15; dd[0] = 32'hAA;
        step();
        clr_stim(); v[0] = 1; ord[0] = 64'd3; sa[0][1] = 4'd15; sd[0][1] = 32'hBB;
        step();
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL pc_unchecked: fail got %0b want 0", fail); end
        total++; if (retired_cnt !== 6'd4) begin bad++; $display("FAIL trap_cnt: got %0d want 4", retired_cnt); end
    endtask

    task automatic test_done();
        enter_track();
        for (int i = 0; i < 15; i++) begin gen_cycle(1, 0); step(); end
        total++; if (retired_cnt !== 6'd30 || done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL pre_done: cnt=%0d done=%0b busy=%0b want 30/0/1", retired_cnt, done, busy);
        end
        gen_cycle(1, 0); step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL done_flag: got %0b want 1", done); end
        total++; if (retired_cnt !== 6'd32) begin bad++; $display("FAIL done_cnt: got %0d want 32", retired_cnt); end
        total++; if (busy !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL done_busy: busy=%0b fail=%0b want 0/0", busy, fail); end
        clr_stim(); v[1] = 1;
        step();
        total++; if (done !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL done_hold: done=%0b fail=%0b want 1/0", done, fail); end
    endtask

    task automatic test_reset_mid();
        enter_track();
        for (int i = 0; i < 4; i++) begin gen_cycle(1, 0); step(); end
        clr_stim(); v[0] = 1; ord[0] = m_exp; da[0] = 4'd4; dd[0] = 32'h1234;
        step();
        total++; if (retired_cnt !== 6'd9) begin bad++; $display("FAIL mid_cnt: got %0d want 9", retired_cnt); end
        reset = 0; clr_stim();
        step();
        total++; if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || retired_cnt !== 6'd0) begin
            bad++; $display("FAIL mid_reset: busy=%0b done=%0b fail=%0b cnt=%0d want all 0", busy, done, fail, retired_cnt);
        end
        enter_track();
        v[0] = 1; ord[0] = 64'd77; sa[0][2] = 4'd4; sd[0][2] = 32'h9999;
        step();
        total++; if (fail !== 1'b0 || retired_cnt !== 6'd1) begin
            bad++; $display("FAIL no_residue: fail=%0b cnt=%0d want 0/1", fail, retired_cnt);
        end
    endtask

    task automatic test_random();
        for (int e = 0; e < 40; e++) begin
            enter_track();
            for (int c = 0; c < 30; c++) begin
                gen_cycle(0, 25);
                step();
                total++; if (busy !== (m_state == 1)) begin bad++; $display("FAIL rnd_busy e%0d c%0d: got %0b want %0b", e, c, busy, m_state == 1); end
                total++; if (done !== m_done) begin bad++; $display("FAIL rnd_done e%0d c%0d: got %0b want %0b", e, c, done, m_done); end
                total++; if (fail !== m_fail) begin bad++; $display("FAIL rnd_fail e%0d c%0d: got %0b want %0b", e, c, fail, m_fail); end
                total++; if (fail_cause !== 2'(m_cause)) begin bad++; $display("FAIL rnd_cause e%0d c%0d: got %0d want %0d", e, c, fail_cause, m_cause); end
                total++; if (fail_chan !== 1'(m_chan)) begin bad++; $display("FAIL rnd_chan e%0d c%0d: got %0d want %0d", e, c, fail_chan, m_chan); end
                total++; if (retired_cnt !== 6'(m_cnt)) begin bad++; $display("FAIL rnd_cnt e%0d c%0d: got %0d want %0d", e, c, retired_cnt, m_cnt); end
            end
        end
    endtask

    initial begin
        reset = 0; check_en = 0;
        clr_stim();
        model_step();
        test_reset();
        test_bypass_next_cycle();
        test_same_cycle_bypass();
        test_gap_and_order();
        test_trap_and_pc();
        test_done();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
